// File: rtl/xrisc_store_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : xrisc_store_checker_if
//  Description : Core data-memory store bus as seen by the store checker.
//                The core (or a bench standing in for it) drives the master
//                side. The checker only observes, through the slave side.
//  Ports       : MemWrite  - store strobe
//                DataAdr   - store address   (XLEN)
//                WriteData - store data      (XLEN)
//  Revision    : 1.0 - initial release
// ============================================================================
interface xrisc_store_checker_if #(
    parameter int XLEN = 32
);
    logic            MemWrite;
    logic [XLEN-1:0] DataAdr;
    logic [XLEN-1:0] WriteData;

    modport master (output MemWrite, output DataAdr, output WriteData);
    modport slave  (input  MemWrite, input  DataAdr, input  WriteData);
endinterface
`default_nettype wire

// File: rtl/xrisc_store_checker.sv
`default_nettype none
// ============================================================================
//  Module      : xrisc_store_checker
//  Description : Store monitor for X-RISC cores. It compares every store seen
//                on the core's data-memory port against a preloaded table of
//                expected (address, data) pairs, in table order, and reports
//                PASS, FAIL or timeout together with the offending store.
//  Ports       : clk, reset_n         - clock, async active-low reset
//                ld_en/ld_idx/ld_addr/ld_data - expected-table load (not in RUN)
//                num_exp, start       - expected store count, run start
//                mem (slave)          - observed store bus
//                busy/done/pass       - run status
//                err_code             - 0 none,1 data,2 address,3 timeout
//                store_cnt, cycle_cnt - matched stores, RUN cycles elapsed
//                bad_addr, bad_data   - captured offending store
//  Revision    : 1.0 - initial release
// ============================================================================
module xrisc_store_checker #(
    parameter  int XLEN    = 32,
    parameter  int DEPTH   = 8,
    parameter  int TIMEOUT = 256,
    localparam int IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW      = $clog2(DEPTH + 1),
    localparam int TW      = $clog2(TIMEOUT + 1)
) (
    input  wire logic                 clk,
    input  wire logic                 reset_n,
    input  wire logic                 ld_en,
    input  wire logic [IW-1:0]        ld_idx,
    input  wire logic [XLEN-1:0]      ld_addr,
    input  wire logic [XLEN-1:0]      ld_data,
    input  wire logic [CW-1:0]        num_exp,
    input  wire logic                 start,
    xrisc_store_checker_if.slave      mem,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [1:0]                err_code,
    output logic [CW-1:0]             store_cnt,
    output logic [TW-1:0]             cycle_cnt,
    output logic [XLEN-1:0]           bad_addr,
    output logic [XLEN-1:0]           bad_data
);

    localparam logic [1:0]    C_ERR_NONE    = 2'd0;
    localparam logic [1:0]    C_ERR_DATA    = 2'd1;
    localparam logic [1:0]    C_ERR_ADDR    = 2'd2;
    localparam logic [1:0]    C_ERR_TIMEOUT = 2'd3;
    localparam logic [CW-1:0] C_DEPTH       = CW'(DEPTH);
    localparam logic [TW-1:0] C_TIMEOUT     = TW'(TIMEOUT);
    localparam logic [TW-1:0] C_TIMEOUT_M1  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PASS = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    state_t            state_q,     state_d;
    logic [CW-1:0]     exp_q,       exp_d;
    logic [CW-1:0]     store_cnt_q, store_cnt_d;
    logic [TW-1:0]     cycle_cnt_q, cycle_cnt_d;
    logic [1:0]        err_q,       err_d;
    logic [XLEN-1:0]   bad_addr_q,  bad_addr_d;
    logic [XLEN-1:0]   bad_data_q,  bad_data_d;

    logic [XLEN-1:0]   tbl_addr_q [DEPTH];
    logic [XLEN-1:0]   tbl_data_q [DEPTH];

    logic [XLEN-1:0]   w_exp_addr;
    logic [XLEN-1:0]   w_exp_data;
    logic [CW-1:0]     w_num_clamped;
    logic [CW-1:0]     w_store_inc;
    logic              w_ld_ok;

    // Loads are only accepted outside RUN so the table cannot change under
    // an active comparison. A load coinciding with start is written on the
    // same edge, which is before the first compared store (next edge).
    assign w_ld_ok = ld_en && (state_q != S_RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_addr_q[i] <= '0;
                tbl_data_q[i] <= '0;
            end
        end else if (w_ld_ok) begin
            tbl_addr_q[ld_idx] <= ld_addr;
            tbl_data_q[ld_idx] <= ld_data;
        end
    end

    // store_cnt is always below the latched count while in RUN, so the low
    // bits always address a valid entry when the result is used.
    assign w_exp_addr    = tbl_addr_q[store_cnt_q[IW-1:0]];
    assign w_exp_data    = tbl_data_q[store_cnt_q[IW-1:0]];
    assign w_num_clamped = (num_exp > C_DEPTH) ? C_DEPTH : num_exp;
    assign w_store_inc   = store_cnt_q + CW'(1);

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        store_cnt_d = store_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        err_d       = err_q;
        bad_addr_d  = bad_addr_q;
        bad_data_d  = bad_data_q;

        case (state_q)
            S_RUN: begin
                if (cycle_cnt_q != C_TIMEOUT) begin
                    cycle_cnt_d = cycle_cnt_q + TW'(1);
                end
                if (mem.MemWrite) begin
                    if (mem.DataAdr != w_exp_addr) begin
                        state_d    = S_FAIL;
                        err_d      = C_ERR_ADDR;
                        bad_addr_d = mem.DataAdr;
                        bad_data_d = mem.WriteData;
                    end else if (mem.WriteData != w_exp_data) begin
                        state_d    = S_FAIL;
                        err_d      = C_ERR_DATA;
                        bad_addr_d = mem.DataAdr;
                        bad_data_d = mem.WriteData;
                    end else begin
                        store_cnt_d = w_store_inc;
                        if (w_store_inc == exp_q) begin
                            state_d = S_PASS;
                        end
                    end
                end
                // Timeout only when this edge made no decision, so a deciding
                // store on the last budgeted edge wins.
                if ((state_d == S_RUN) && (cycle_cnt_q == C_TIMEOUT_M1)) begin
                    state_d = S_FAIL;
                    err_d   = C_ERR_TIMEOUT;
                end
            end
            default: begin
                if (start) begin
                    exp_d       = w_num_clamped;
                    store_cnt_d = '0;
                    cycle_cnt_d = '0;
                    err_d       = C_ERR_NONE;
                    bad_addr_d  = '0;
                    bad_data_d  = '0;
                    state_d     = (w_num_clamped == '0) ? S_PASS : S_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            exp_q       <= '0;
            store_cnt_q <= '0;
            cycle_cnt_q <= '0;
            err_q       <= C_ERR_NONE;
            bad_addr_q  <= '0;
            bad_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            store_cnt_q <= store_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            err_q       <= err_d;
            bad_addr_q  <= bad_addr_d;
            bad_data_q  <= bad_data_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_PASS) || (state_q == S_FAIL);
    assign pass      = (state_q == S_PASS);
    assign err_code  = err_q;
    assign store_cnt = store_cnt_q;
    assign cycle_cnt = cycle_cnt_q;
    assign bad_addr  = bad_addr_q;
    assign bad_data  = bad_data_q;

endmodule
`default_nettype wire
